// File: rtl/inst_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_pkg
// Shared constants for the instruction-memory loader: HLT word, byte width,
// default widths and the loader state encoding.
// Optional feature macro: INST_LOADER_CHECKSUM_EN (adds the CHECK state).
// ---------------------------------------------------------------------------
package inst_mem_loader_pkg;

    localparam int BYTE_BITS                = 8;
    localparam logic [31:0] HLT_INSTRUCTION = 32'hFFFF_FFFF;

    localparam int DEFAULT_PC_BITS          = 32;
    localparam int DEFAULT_INSTRUCTION_BITS = 32;
    localparam int DEFAULT_INST_ADDRS_BITS  = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3
`ifdef INST_LOADER_CHECKSUM_EN
        ,
        ST_CHECK = 3'd4
`endif
    } loader_state_e;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// inst_mem_loader_byte_packer
// Shift register plus byte counter that packs an MSB-first byte stream into
// instruction words and pulses o_word_ready on the last byte of each word.
// Optional feature macro: INST_LOADER_CHECKSUM_EN (not used in this file).
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_clear        drop any partial word (start of a new load)
//   i_byte_valid   i_byte is to be shifted in this cycle
//   i_byte         received byte
//   o_word_next    word value including this cycle's byte (valid with ready)
//   o_word_ready   this cycle's byte completes a word
// ---------------------------------------------------------------------------
module inst_mem_loader_byte_packer
    import inst_mem_loader_pkg::*;
#(
    parameter int INSTRUCTION_BITS = DEFAULT_INSTRUCTION_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_byte_valid,
    input  logic [BYTE_BITS-1:0]        i_byte,
    output logic [INSTRUCTION_BITS-1:0] o_word_next,
    output logic                        o_word_ready
);

    localparam int BYTES_PER_WORD = INSTRUCTION_BITS / BYTE_BITS;
    localparam int CNT_BITS       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BYTES_PER_WORD - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [INSTRUCTION_BITS-1:0] word_q, word_d;
    logic [CNT_BITS-1:0]         cnt_q, cnt_d;

    // The completed word is exposed combinationally so the loader can register
    // it into the write-data output on the same edge that enters WRITE.
    always_comb begin
        word_d       = word_q;
        cnt_d        = cnt_q;
        o_word_ready = 1'b0;
        if (i_clear) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (i_byte_valid) begin
            word_d = (word_q << BYTE_BITS) | INSTRUCTION_BITS'(i_byte);
            if (cnt_q == CNT_LAST) begin
                cnt_d        = '0;
                o_word_ready = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_word_next = word_d;

endmodule

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Writer side of the instruction-memory load port. Packs UART bytes into
// instructions and writes them from address 0 until the HLT word is written
// or memory is full, then reports completion.
// Optional feature macro: INST_LOADER_CHECKSUM_EN -- after HLT, the next byte
// is compared against a running XOR of all data bytes (o_checksum_err).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             pulse: begin a load (ignored while busy)
//   i_rx_data/i_rx_done received byte and its one-cycle strobe
//   o_write_inst_mem    one-cycle write enable (also freezes the PC)
//   o_inst_mem_addr     word address, zero-extended
//   o_inst_mem_data     assembled instruction
//   o_busy              loading in progress
//   o_load_done         load finished
//   o_overflow          memory filled before HLT (sticky until i_start)
//   o_checksum_err      checksum mismatch (only with INST_LOADER_CHECKSUM_EN)
//   o_inst_count        words written in the current load
// ---------------------------------------------------------------------------
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int PC_BITS          = DEFAULT_PC_BITS,
    parameter int INSTRUCTION_BITS = DEFAULT_INSTRUCTION_BITS,
    parameter int INST_ADDRS_BITS  = DEFAULT_INST_ADDRS_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic [BYTE_BITS-1:0]        i_rx_data,
    input  logic                        i_rx_done,
    output logic                        o_write_inst_mem,
    output logic [PC_BITS-1:0]          o_inst_mem_addr,
    output logic [INSTRUCTION_BITS-1:0] o_inst_mem_data,
    output logic                        o_busy,
    output logic                        o_load_done,
    output logic                        o_overflow,
`ifdef INST_LOADER_CHECKSUM_EN
    output logic                        o_checksum_err,
`endif
    output logic [INST_ADDRS_BITS:0]    o_inst_count
);

    // HLT is the all-ones word; replicate its byte so wider words still match.
    localparam logic [INSTRUCTION_BITS-1:0] HLT_WORD =
        {(INSTRUCTION_BITS/BYTE_BITS){HLT_INSTRUCTION[BYTE_BITS-1:0]}};
    localparam logic [INST_ADDRS_BITS-1:0] ADDR_LAST = '1;
    localparam logic [INST_ADDRS_BITS-1:0] ADDR_ONE  = INST_ADDRS_BITS'(1);
    localparam logic [INST_ADDRS_BITS:0]   COUNT_ONE = (INST_ADDRS_BITS+1)'(1);

    loader_state_e                 state_q, state_d;
    logic [INST_ADDRS_BITS-1:0]    addr_q, addr_d;
    logic [INST_ADDRS_BITS:0]      count_q, count_d;
    logic                          overflow_q, overflow_d;
    logic                          write_q, write_d;
    logic [PC_BITS-1:0]            mem_addr_q, mem_addr_d;
    logic [INSTRUCTION_BITS-1:0]   mem_data_q, mem_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [BYTE_BITS-1:0]          csum_q, csum_d;
    logic                          csum_err_q, csum_err_d;
`endif

    logic                          start_take;
    logic                          write_continues;
    logic                          byte_take;
    logic                          word_ready;
    logic [INSTRUCTION_BITS-1:0]   word_next;

    // A byte in the WRITE cycle belongs to the next word only if the load
    // carries on; in the final WRITE cycle it is dropped like any late byte.
    assign start_take      = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign write_continues = (mem_data_q != HLT_WORD) && (addr_q != ADDR_LAST);
    assign byte_take       = i_rx_done &&
                             ((state_q == ST_RECV) || ((state_q == ST_WRITE) && write_continues));

    inst_mem_loader_byte_packer #(
        .INSTRUCTION_BITS (INSTRUCTION_BITS)
    ) u_byte_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (start_take),
        .i_byte_valid (byte_take),
        .i_byte       (i_rx_data),
        .o_word_next  (word_next),
        .o_word_ready (word_ready)
    );

    // Next-state logic. The write strobe, address and data are loaded on the
    // edge that enters WRITE, so the strobe lands one cycle after the last
    // byte. Address and data simply hold outside WRITE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        write_d    = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        csum_err_d = csum_err_q;
        if (byte_take) begin
            csum_d = csum_q ^ i_rx_data;
        end
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_take) begin
                    state_d    = ST_RECV;
                    addr_d     = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    csum_err_d = 1'b0;
`endif
                end
            end
            ST_RECV: begin
                if (word_ready) begin
                    state_d    = ST_WRITE;
                    write_d    = 1'b1;
                    mem_addr_d = PC_BITS'(addr_q);
                    mem_data_d = word_next;
                end
            end
            ST_WRITE: begin
                count_d = count_q + COUNT_ONE;
                if (mem_data_q == HLT_WORD) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else if (addr_q == ADDR_LAST) begin
                    state_d    = ST_DONE;
                    overflow_d = 1'b1;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = ST_RECV;
                    // Only reachable with one-byte words: back-to-back writes.
                    if (word_ready) begin
                        state_d    = ST_WRITE;
                        write_d    = 1'b1;
                        mem_addr_d = PC_BITS'(addr_d);
                        mem_data_d = word_next;
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_rx_done) begin
                    csum_err_d = (i_rx_data != csum_q);
                    state_d    = ST_DONE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RECV) || (state_d == ST_WRITE);
`ifdef INST_LOADER_CHECKSUM_EN
        busy_d = busy_d || (state_d == ST_CHECK);
`endif
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            write_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            csum_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            write_q    <= write_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            csum_err_q <= csum_err_d;
`endif
        end
    end

    assign o_write_inst_mem = write_q;
    assign o_inst_mem_addr  = mem_addr_q;
    assign o_inst_mem_data  = mem_data_q;
    assign o_busy           = busy_q;
    assign o_load_done      = done_q;
    assign o_overflow       = overflow_q;
    assign o_inst_count     = count_q;
`ifdef INST_LOADER_CHECKSUM_EN
    assign o_checksum_err   = csum_err_q;
`endif

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction-memory load port used by the fetch stage.
- Receives a byte stream from the debug UART receiver and packs the bytes into instructions.
- Issues one-cycle write strobes (write enable, address, data) into instruction memory, starting at address 0.
- Stops after writing the HLT word (32'hFFFFFFFF), or when memory is full, and then signals completion to the debug unit.

Parameters:
- PC_BITS, `PC_BITS (32): width of the address output.
- INSTRUCTION_BITS, `INSTRUCTION_BITS (32): instruction width. Must be a multiple of 8.
- INST_ADDRS_BITS, `INST_ADDRS_BITS (10): instruction memory depth is 2^INST_ADDRS_BITS words.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle pulse from the debug unit that begins a load.
- i_rx_data  in  8  received byte.
- i_rx_done  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
- o_write_inst_mem  out  1  write enable to instruction memory. Also freezes the PC.
- o_inst_mem_addr  out  PC_BITS  write address (word index), zero-extended from INST_ADDRS_BITS.
- o_inst_mem_data  out  INSTRUCTION_BITS  assembled instruction.
- o_busy  out  1  high while in the RECV or WRITE state (and CHECK when the optional feature is enabled).
- o_load_done  out  1  held high in the DONE state.
- o_overflow  out  1  memory filled before HLT was received. Sticky until the next i_start.
- o_inst_count  out  INST_ADDRS_BITS+1  number of words written in the current load.

Behaviour:
- Reset: all outputs 0, state IDLE, address 0, byte counter 0, shift register 0. Reset mid-load discards any partial word and makes no further writes.
- States: IDLE, RECV, WRITE, DONE (plus CHECK with the optional feature).
- IDLE:
  - i_rx_done is ignored.
  - i_start -> RECV. Clear address, byte counter, o_inst_count and o_overflow.
- RECV:
  - On i_rx_done: word <= {word[INSTRUCTION_BITS-9:0], i_rx_data}, so the MSB is received first.
  - Byte counter increments on each byte.
  - On the (INSTRUCTION_BITS/8)-th byte: go to WRITE next cycle and reset the byte counter to 0.
  - i_start while busy is ignored.
- WRITE (exactly one cycle):
  - o_write_inst_mem=1, o_inst_mem_addr=address, o_inst_mem_data=word.
  - These three outputs are registered. They are 0, address-hold and data-hold outside WRITE; only the enable is qualified.
  - o_inst_count increments at the end of the cycle.
  - If word==HLT -> DONE.
  - Else if address==2^INST_ADDRS_BITS-1 -> DONE and set o_overflow.
  - Else address+1 -> RECV.
  - An i_rx_done arriving in the WRITE cycle is accepted as byte 0 of the next word (byte counter -> 1). No byte is lost.
- DONE:
  - o_load_done=1. Bytes are ignored.
  - i_start -> RECV (reload from address 0, flags cleared).
- Latency: the write strobe is asserted in the cycle after the last byte strobe of a word.
- Address never wraps. A full-memory load terminates rather than overwriting address 0.
- i_start and i_rx_done in the same IDLE/DONE cycle: start is taken and the byte is dropped.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- When defined:
  - A running 8-bit XOR of every data byte is kept, cleared on i_start.
  - After the HLT write the FSM enters CHECK instead of DONE.
  - The next received byte is compared with the running XOR; a mismatch sets output o_checksum_err (1 bit, sticky until i_start). Then -> DONE.
  - The overflow path skips CHECK.
- When undefined: no CHECK state, no o_checksum_err port, and HLT goes directly to DONE.

Decomposition:
- Shared constants header (existing constants file): HLT_INSTRUCTION (32'hFFFFFFFF), BYTE_BITS (8), loader state encodings.
- One natural sub-module, byte_packer: shift register plus byte counter that emits a word-ready pulse. The FSM, address counter and flags stay in inst_mem_loader.

Test Plan:
- Reset, pulse i_start, send bytes 20 01 00 05 FF FF FF FF:
  - write at addr 0 with data 0x20010005, then write at addr 1 with data 0xFFFFFFFF;
  - o_load_done=1, o_inst_count=2, exactly 2 write strobes.
- Byte strobes 1 cycle apart, including a strobe in the WRITE cycle -> all words are assembled correctly with no dropped byte.
- With INST_ADDRS_BITS=2, send 4 non-HLT words:
  - writes at addr 0..3;
  - o_overflow=1, o_load_done=1, o_inst_count=4, no write to addr 0 afterwards.
- Assert rst after 2 bytes of a word:
  - all outputs 0, no write;
  - a new i_start plus a full word writes addr 0 cleanly.
- Bytes before i_start and after DONE are ignored. A second i_start in DONE reloads from addr 0 and clears o_overflow.
- With INST_LOADER_CHECKSUM_EN:
  - send 20 01 00 05 FF FF FF FF then checksum 0x24 -> o_checksum_err=0;
  - repeat with checksum 0x00 -> o_checksum_err=1.
